pwm_cmd_sched: RTL and testbench



---
 rtl/pwm_cmd_sched_pkg.sv | 36 +++
 rtl/pwm_cmd_sched_if.sv | 37 +++
 rtl/pwm_cmd_sched_sync_fifo.sv | 63 ++++++
 rtl/pwm_cmd_sched.sv | 238 +++++++++++++++++++++++
 tb/tb_pwm_cmd_sched.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_cmd_sched_pkg.sv
// Shared definitions for the PWM command scheduler: function codes,
// packet field positions within pkt_data, FSM encoding and a small helper.
package pwm_cmd_pkg;

    localparam logic [7:0] FUNC_CFG = 8'h01;
    localparam logic [7:0] FUNC_EN  = 8'h02;

    localparam int PKT_FUNC_W  = 8;
    localparam int PKT_DATA_W  = 80;
    localparam int CMD_ENTRY_W = PKT_FUNC_W + PKT_DATA_W;

    // Field LSBs within pkt_data (rev_data1 occupies [79:72]).
    localparam int CH_LSB      = 72;
    localparam int D2_LSB      = 64;
    localparam int DUTY_LSB    = 56;
    localparam int DESSERT_LSB = 40;
    localparam int PULSE_LSB   = 32;
    localparam int PAT_LSB     = 0;

    // Everything below the channel byte is held as the command payload.
    localparam int CMD_DATA_W  = CH_LSB;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_DISABLE   = 3'd2,
        ST_WAIT_IDLE = 3'd3,
        ST_WRITE     = 3'd4,
        ST_RESTORE   = 3'd5
    } sched_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pwm_cmd_sched_if.sv
// Bundle of the packet input, channel status, config write bus and status
// flags exchanged between the scheduler and its surroundings.
interface pwm_cmd_sched_if #(
    parameter int NUM_CHANNELS = 3
);
    import pwm_cmd_pkg::*;

    logic                    pkt_valid;
    logic [PKT_FUNC_W-1:0]   pkt_func;
    logic [PKT_DATA_W-1:0]   pkt_data;
    logic [NUM_CHANNELS-1:0] ch_busy;
    logic                    sts_clr;

    logic                    wr_valid;
    logic [7:0]              wr_ch;
    logic [7:0]              wr_duty;
    logic [15:0]             wr_dessert;
    logic [7:0]              wr_pulse_num;
    logic [31:0]             wr_pat;
    logic [NUM_CHANNELS-1:0] ch_en;
    logic                    fifo_ovf;
    logic                    timeout_flag;
    logic [7:0]              err_cnt;

    modport master (
        output pkt_valid, pkt_func, pkt_data, ch_busy, sts_clr,
        input  wr_valid, wr_ch, wr_duty, wr_dessert, wr_pulse_num, wr_pat,
        input  ch_en, fifo_ovf, timeout_flag, err_cnt
    );

    modport slave (
        input  pkt_valid, pkt_func, pkt_data, ch_busy, sts_clr,
        output wr_valid, wr_ch, wr_duty, wr_dessert, wr_pulse_num, wr_pat,
        output ch_en, fifo_ovf, timeout_flag, err_cnt
    );

endinterface

// File: rtl/pwm_cmd_sched_sync_fifo.sv
// Single-clock show-ahead FIFO. A push while full is still accepted when a
// pop happens in the same cycle; otherwise the push is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem_q[rd_ptr_q];

    // Pointer and occupancy update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage; contents are only meaningful while counted, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/pwm_cmd_sched.sv
// Command scheduler: buffers decoded UART packets and applies them to the
// pattern channel bank in order, never reconfiguring an enabled or busy
// channel. Owns the per-channel enable vector.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | wait for a queued command, pop it into the cmd registers
// DECODE     | classify command; apply enable commands, count bad ones
// DISABLE    | drop the target enable and remember to restore it
// WAIT_IDLE  | wait for the target to go idle, bounded by TIMEOUT cycles
// WRITE      | one-cycle config write strobe; restore enable on exit
// RESTORE    | clear the pending-restore marker
module pwm_cmd_sched
    import pwm_cmd_pkg::*;
#(
    parameter int NUM_CHANNELS = 3,
    parameter int FIFO_DEPTH   = 4,
    parameter int TIMEOUT      = 1024
) (
    input  logic           clk_50M,
    input  logic           rst,
    pwm_cmd_sched_if.slave bus
);

    localparam int             TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  WAIT_LOAD = TW'(TIMEOUT - 1);

    sched_state_t            state_q, state_d;
    logic [7:0]              cmd_func_q, cmd_func_d;
    logic [7:0]              cmd_ch_q, cmd_ch_d;
    logic [CMD_DATA_W-1:0]   cmd_data_q, cmd_data_d;
    logic                    saved_en_q, saved_en_d;
    logic [TW-1:0]           wait_cnt_q, wait_cnt_d;
    logic [NUM_CHANNELS-1:0] ch_en_q, ch_en_d;

    logic                    wr_valid_q, wr_valid_d;
    logic [7:0]              wr_ch_q, wr_ch_d;
    logic [7:0]              wr_duty_q, wr_duty_d;
    logic [15:0]             wr_dessert_q, wr_dessert_d;
    logic [7:0]              wr_pulse_num_q, wr_pulse_num_d;
    logic [31:0]             wr_pat_q, wr_pat_d;

    logic                    fifo_ovf_q, fifo_ovf_d;
    logic                    timeout_flag_q, timeout_flag_d;
    logic [7:0]              err_cnt_q, err_cnt_d;

    logic                    fifo_pop, fifo_full, fifo_empty, fifo_drop;
    logic [CMD_ENTRY_W-1:0]  fifo_wdata, fifo_rdata;
    logic [NUM_CHANNELS-1:0] ch_mask;
    logic                    ch_ok, ch_busy_sel, ch_en_sel;
    logic                    load_wr, timeout_set, err_inc;

    // Only bit 0 of data2 carries meaning (the enable value).
    logic                    unused_data2_hi;
    assign unused_data2_hi = ^cmd_data_q[D2_LSB+1 +: 7];

    assign fifo_wdata = {bus.pkt_func, bus.pkt_data};
    assign fifo_drop  = bus.pkt_valid && fifo_full && !fifo_pop;

    sync_fifo #(
        .WIDTH (CMD_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_50M),
        .rst   (rst),
        .push  (bus.pkt_valid),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ch_mask     = NUM_CHANNELS'(1) << cmd_ch_q;
    assign ch_ok       = (cmd_ch_q < 8'(NUM_CHANNELS));
    assign ch_busy_sel = |(bus.ch_busy & ch_mask);
    assign ch_en_sel   = |(ch_en_q & ch_mask);

    // Next-state and datapath for the command sequencer.
    always_comb begin
        state_d        = state_q;
        cmd_func_d     = cmd_func_q;
        cmd_ch_d       = cmd_ch_q;
        cmd_data_d     = cmd_data_q;
        saved_en_d     = saved_en_q;
        wait_cnt_d     = wait_cnt_q;
        ch_en_d        = ch_en_q;
        wr_valid_d     = 1'b0;
        wr_ch_d        = wr_ch_q;
        wr_duty_d      = wr_duty_q;
        wr_dessert_d   = wr_dessert_q;
        wr_pulse_num_d = wr_pulse_num_q;
        wr_pat_d       = wr_pat_q;
        fifo_pop       = 1'b0;
        load_wr        = 1'b0;
        timeout_set    = 1'b0;
        err_inc        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    cmd_func_d = fifo_rdata[PKT_DATA_W +: PKT_FUNC_W];
                    cmd_ch_d   = fifo_rdata[CH_LSB +: 8];
                    cmd_data_d = fifo_rdata[CMD_DATA_W-1:0];
                    state_d    = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (cmd_func_q == FUNC_CFG && ch_ok) begin
                    if (ch_en_sel) begin
                        state_d = ST_DISABLE;
                    end else if (ch_busy_sel) begin
                        wait_cnt_d = WAIT_LOAD;
                        state_d    = ST_WAIT_IDLE;
                    end else begin
                        load_wr = 1'b1;
                    end
                end else if (cmd_func_q == FUNC_EN && ch_ok) begin
                    ch_en_d = cmd_data_q[D2_LSB] ? (ch_en_q | ch_mask)
                                                 : (ch_en_q & ~ch_mask);
                    state_d = ST_IDLE;
                end else begin
                    err_inc = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DISABLE: begin
                ch_en_d    = ch_en_q & ~ch_mask;
                saved_en_d = 1'b1;
                wait_cnt_d = WAIT_LOAD;
                state_d    = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (!ch_busy_sel) begin
                    load_wr = 1'b1;
                end else if (wait_cnt_q == '0) begin
                    timeout_set = 1'b1;
                    load_wr     = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - TW'(1);
                end
            end
            ST_WRITE: begin
                // Enable comes back on the WRITE->RESTORE edge so it is
                // visible the cycle right after the strobe.
                if (saved_en_q) begin
                    ch_en_d = ch_en_q | ch_mask;
                    state_d = ST_RESTORE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESTORE: begin
                saved_en_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_wr) begin
            wr_valid_d     = 1'b1;
            wr_ch_d        = cmd_ch_q;
            wr_duty_d      = cmd_data_q[DUTY_LSB +: 8];
            wr_dessert_d   = cmd_data_q[DESSERT_LSB +: 16];
            wr_pulse_num_d = cmd_data_q[PULSE_LSB +: 8];
            wr_pat_d       = cmd_data_q[PAT_LSB +: 32];
            state_d        = ST_WRITE;
        end
    end

    // Sticky status; a set event in the same cycle beats sts_clr.
    always_comb begin
        fifo_ovf_d     = fifo_ovf_q;
        timeout_flag_d = timeout_flag_q;
        err_cnt_d      = err_cnt_q;
        if (bus.sts_clr) begin
            fifo_ovf_d     = 1'b0;
            timeout_flag_d = 1'b0;
            err_cnt_d      = 8'd0;
        end
        if (fifo_drop)   fifo_ovf_d     = 1'b1;
        if (timeout_set) timeout_flag_d = 1'b1;
        if (err_inc)     err_cnt_d      = sat_inc8(err_cnt_q);
    end

    // State and output registers.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cmd_func_q     <= 8'd0;
            cmd_ch_q       <= 8'd0;
            cmd_data_q     <= '0;
            saved_en_q     <= 1'b0;
            wait_cnt_q     <= '0;
            ch_en_q        <= '0;
            wr_valid_q     <= 1'b0;
            wr_ch_q        <= 8'd0;
            wr_duty_q      <= 8'd0;
            wr_dessert_q   <= 16'd0;
            wr_pulse_num_q <= 8'd0;
            wr_pat_q       <= 32'd0;
            fifo_ovf_q     <= 1'b0;
            timeout_flag_q <= 1'b0;
            err_cnt_q      <= 8'd0;
        end else begin
            state_q        <= state_d;
            cmd_func_q     <= cmd_func_d;
            cmd_ch_q       <= cmd_ch_d;
            cmd_data_q     <= cmd_data_d;
            saved_en_q     <= saved_en_d;
            wait_cnt_q     <= wait_cnt_d;
            ch_en_q        <= ch_en_d;
            wr_valid_q     <= wr_valid_d;
            wr_ch_q        <= wr_ch_d;
            wr_duty_q      <= wr_duty_d;
            wr_dessert_q   <= wr_dessert_d;
            wr_pulse_num_q <= wr_pulse_num_d;
            wr_pat_q       <= wr_pat_d;
            fifo_ovf_q     <= fifo_ovf_d;
            timeout_flag_q <= timeout_flag_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    // A strobe registered just before reset must not leak into the reset cycle.
    assign bus.wr_valid     = wr_valid_q && !rst;
    assign bus.wr_ch        = wr_ch_q;
    assign bus.wr_duty      = wr_duty_q;
    assign bus.wr_dessert   = wr_dessert_q;
    assign bus.wr_pulse_num = wr_pulse_num_q;
    assign bus.wr_pat       = wr_pat_q;
    assign bus.ch_en        = ch_en_q;
    assign bus.fifo_ovf     = fifo_ovf_q;
    assign bus.timeout_flag = timeout_flag_q;
    assign bus.err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_pwm_cmd_sched.sv
// Scoreboard bench for pwm_cmd_sched: stimulus queues expected config writes,
// a monitor pops and compares each wr_valid strobe.
module tb_pwm_cmd_sched;
    import pwm_cmd_pkg::*;

    localparam int NCH = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   n_writes = 0;

    typedef struct {
        logic [7:0]  ch;
        logic [7:0]  duty;
        logic [15:0] dessert;
        logic [7:0]  pulse;
        logic [31:0] pat;
        int          at;
    } wr_exp_t;

    wr_exp_t exp_q[$];

    pwm_cmd_sched_if #(.NUM_CHANNELS(NCH)) bus();

    pwm_cmd_sched #(
        .NUM_CHANNELS (NCH),
        .FIFO_DEPTH   (4),
        .TIMEOUT      (16)
    ) dut (
        .clk_50M (clk),
        .rst     (rst),
        .bus     (bus.slave)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic expect_wr(input logic [7:0] ch, input logic [7:0] duty,
                             input logic [15:0] dessert, input logic [7:0] pulse,
                             input logic [31:0] pat, input int at);
        wr_exp_t e;
        e.ch = ch; e.duty = duty; e.dessert = dessert;
        e.pulse = pulse; e.pat = pat; e.at = at;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; the packet is sampled at the following posedge.
    task automatic send(input logic [7:0] func, input logic [7:0] ch, input logic [7:0] d2,
                        input logic [7:0] duty, input logic [15:0] dessert,
                        input logic [7:0] pulse, input logic [31:0] pat, output int t);
        bus.pkt_func  = func;
        bus.pkt_data  = {ch, d2, duty, dessert, pulse, pat};
        bus.pkt_valid = 1'b1;
        t = cyc;
        @(negedge clk);
        bus.pkt_valid = 1'b0;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic pulse_clr();
        bus.sts_clr = 1'b1;
        @(negedge clk);
        bus.sts_clr = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    initial begin
        wr_exp_t e;
        forever begin
            @(negedge clk);
            if (bus.wr_valid === 1'b1) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_write: wr_valid=1 ch=0x%0h duty=0x%0h, expected no write (cycle %0d)",
                             bus.wr_ch, bus.wr_duty, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_ch", bus.wr_ch, e.ch);
                    check("wr_duty", bus.wr_duty, e.duty);
                    check("wr_dessert", bus.wr_dessert, e.dessert);
                    check("wr_pulse_num", bus.wr_pulse_num, e.pulse);
                    check("wr_pat", bus.wr_pat, e.pat);
                    if (e.at >= 0) check("wr_cycle", 64'(cyc), 64'(e.at));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bus.pkt_valid = 1'b0;
        bus.pkt_func  = 8'd0;
        bus.pkt_data  = '0;
        bus.ch_busy   = '0;
        bus.sts_clr   = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_wr_valid", bus.wr_valid, 0);
        check("rst_wr_fields", {bus.wr_ch, bus.wr_duty, bus.wr_dessert, bus.wr_pulse_num}, 0);
        check("rst_wr_pat", bus.wr_pat, 0);
        check("rst_ch_en", bus.ch_en, 0);
        check("rst_flags", {bus.fifo_ovf, bus.timeout_flag, bus.err_cnt}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Config write to a disabled, idle channel: strobe at t+3.
        expect_wr(8'd1, 8'h20, 16'h0010, 8'h05, 32'hDEADBEEF, cyc + 3);
        send(FUNC_CFG, 8'd1, 8'h00, 8'h20, 16'h0010, 8'h05, 32'hDEADBEEF, t);
        wait_to(t + 6);
        check("cfg_ch_en_unchanged", bus.ch_en, 3'b000);

        // Enable command: ch_en updates at t+3, not before.
        send(FUNC_EN, 8'd0, 8'h01, 8'h00, 16'h0000, 8'h00, 32'h0, t);
        wait_to(t + 2);
        check("en_before", bus.ch_en, 3'b000);
        wait_to(t + 3);
        check("en_after", bus.ch_en, 3'b001);
        wait_to(t + 5);

        // Enabled channel, busy for 10 cycles.
        bus.ch_busy[0] = 1'b1;
        expect_wr(8'd0, 8'h40, 16'h1234, 8'h02, 32'hCAFEF00D, cyc + 11);
        send(FUNC_CFG, 8'd0, 8'h00, 8'h40, 16'h1234, 8'h02, 32'hCAFEF00D, t);
        wait_to(t + 3);
        check("busy_en_still_on", bus.ch_en, 3'b001);
        wait_to(t + 4);
        check("busy_en_dropped", bus.ch_en, 3'b000);
        wait_to(t + 10);
        bus.ch_busy[0] = 1'b0;
        wait_to(t + 11);
        check("busy_en_off_at_write", bus.ch_en, 3'b000);
        wait_to(t + 12);
        check("busy_en_restored", bus.ch_en, 3'b001);
        wait_to(t + 14);

        // Stuck busy on ch2: forced write after 16 WAIT_IDLE cycles.
        bus.ch_busy[2] = 1'b1;
        expect_wr(8'd2, 8'h77, 16'hABCD, 8'h09, 32'h01234567, cyc + 19);
        send(FUNC_CFG, 8'd2, 8'h00, 8'h77, 16'hABCD, 8'h09, 32'h01234567, t);
        wait_to(t + 18);
        check("timeout_flag_before", bus.timeout_flag, 0);
        wait_to(t + 19);
        check("timeout_flag_set", bus.timeout_flag, 1);
        wait_to(t + 21);
        bus.ch_busy[2] = 1'b0;
        pulse_clr();
        check("timeout_flag_cleared", bus.timeout_flag, 0);
        check("ch_en_after_timeout", bus.ch_en, 3'b001);

        // Rejected packets: bad channel, bad function.
        send(FUNC_CFG, 8'd5, 8'h00, 8'h11, 16'h1111, 8'h11, 32'h11111111, t);
        send(8'h07, 8'd0, 8'h01, 8'h22, 16'h2222, 8'h22, 32'h22222222, t);
        wait_to(t + 2);
        check("err_cnt_one", bus.err_cnt, 8'd1);
        wait_to(t + 5);
        check("err_cnt_two", bus.err_cnt, 8'd2);
        check("err_ch_en_untouched", bus.ch_en, 3'b001);
        pulse_clr();
        check("err_cnt_cleared", bus.err_cnt, 8'd0);

        // Overflow: six back-to-back packets while ch0 is busy.
        bus.ch_busy[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 5)
                expect_wr(8'd0, 8'(8'h10 + i), 16'(16'h0100 + i), 8'(i + 1), 32'h50000000 + 32'(i), -1);
            if (i == 5) check("ovf_before_sixth", bus.fifo_ovf, 0);
            send(FUNC_CFG, 8'd0, 8'h00, 8'(8'h10 + i), 16'(16'h0100 + i), 8'(i + 1),
                 32'h50000000 + 32'(i), t);
        end
        check("ovf_set", bus.fifo_ovf, 1);
        wait_to(t + 3);
        bus.ch_busy[0] = 1'b0;
        drain("ovf_drain");
        repeat (20) @(negedge clk);
        check("ovf_ch_en_restored", bus.ch_en, 3'b001);
        check("ovf_no_timeout", bus.timeout_flag, 0);

        // Reset while waiting: in-flight and queued commands are flushed.
        bus.ch_busy[1] = 1'b1;
        send(FUNC_CFG, 8'd1, 8'h00, 8'hE1, 16'hE1E1, 8'hE1, 32'hE1E1E1E1, t);
        send(FUNC_CFG, 8'd2, 8'h00, 8'hE2, 16'hE2E2, 8'hE2, 32'hE2E2E2E2, t);
        wait_to(t + 5);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_wr_valid", bus.wr_valid, 0);
        check("mid_rst_ch_en", bus.ch_en, 3'b000);
        check("mid_rst_flags", {bus.fifo_ovf, bus.timeout_flag, bus.err_cnt}, 0);
        check("mid_rst_wr_fields", {bus.wr_ch, bus.wr_duty, bus.wr_dessert, bus.wr_pulse_num}, 0);
        rst = 1'b0;
        bus.ch_busy[1] = 1'b0;
        repeat (30) @(negedge clk);

        // Fresh packet after reset runs at t+3, so nothing was left queued.
        expect_wr(8'd2, 8'h5A, 16'hA5A5, 8'h03, 32'h0BADCAFE, cyc + 3);
        send(FUNC_CFG, 8'd2, 8'h00, 8'h5A, 16'hA5A5, 8'h03, 32'h0BADCAFE, t);
        wait_to(t + 8);
        check("post_rst_ch_en", bus.ch_en, 3'b000);

        drain("final_drain");
        check("write_count", 64'(n_writes), 64'd9);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
